uart_frame_receiver: RTL and testbench

//  Serial-to-parallel UART receiver, 8N1, LSB first; the receive end of the FPGA_SERIAL_RX/TX link.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_frame_receiver.sv | 157 +++++++++++++++
 tb/tb_uart_frame_receiver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, data width, baud tick math
// and the 2-of-3 majority vote used to decide each bit value.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

   function automatic int tick_div(input int clock_freq, input int baud_rate, input int oversample);
      return clock_freq / (baud_rate * oversample);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every TICK_DIV clks. A synchronous
// restart zeroes the count so the tick phase can be aligned to a start edge.
module uart_baud_tick #(
   parameter int TICK_DIV = 54
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q + CW'(1);
      if (restart) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         tick  = 1'b1;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled majority-vote FSM and a
// 1-entry ready/valid output buffer with framing-error and overrun pulses.
module uart_frame_receiver #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       frame_error,
   output logic       overrun
);
   import uart_pkg::*;

   localparam int TICK_DIV = tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int SW       = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_W - 1);

   logic              rx_meta_q, rx_sync_q;
   rx_state_e         state_q, state_d;
   logic [SW-1:0]     s_q, s_d, s_next;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [1:0]        vote_q, vote_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              valid_q, valid_d;
   logic              frame_error_q, frame_error_d;
   logic              overrun_q, overrun_d;
   logic              tick, restart, complete, vote;

   uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      state_d       = state_q;
      s_d           = s_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      vote_d        = vote_q;
      data_out_d    = data_out_q;
      valid_d       = valid_q;
      frame_error_d = 1'b0;
      overrun_d     = 1'b0;
      restart       = 1'b0;
      complete      = 1'b0;
      s_next        = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      vote          = maj3(vote_q[1], vote_q[0], rx_sync_q);

      case (state_q)
         IDLE: begin
            if (!rx_sync_q) begin
               state_d = START;
               s_d     = '0;
               restart = 1'b1;
            end
         end
         BREAK: begin
            if (rx_sync_q) state_d = IDLE;
         end
         default: begin
            if (tick) begin
               s_d = s_next;
               if (s_next == S_A) vote_d[1] = rx_sync_q;
               if (s_next == S_B) vote_d[0] = rx_sync_q;
               // Third vote sample is the live rx; the bit decision is made here.
               if (s_next == S_C) begin
                  case (state_q)
                     START: if (vote) state_d = IDLE;
                     DATA:  shift_d[bit_idx_q] = vote;
                     STOP: begin
                        if (vote) begin
                           complete = 1'b1;
                           state_d  = IDLE;
                        end else begin
                           frame_error_d = 1'b1;
                           state_d       = BREAK;
                        end
                     end
                     default: ;
                  endcase
               end
               if (s_q == S_LAST) begin
                  case (state_q)
                     START: begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                     end
                     DATA: begin
                        if (bit_idx_q == IDX_LAST) state_d = STOP;
                        else bit_idx_d = bit_idx_q + 3'd1;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase

      // A pop in the completion cycle frees the slot for the new byte.
      if (complete) begin
         if (!valid_q || data_out_ready) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && data_out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         state_q       <= IDLE;
         s_q           <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         vote_q        <= '0;
         data_out_q    <= '0;
         valid_q       <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         rx_meta_q     <= serial_in;
         rx_sync_q     <= rx_meta_q;
         state_q       <= state_d;
         s_q           <= s_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         vote_q        <= vote_d;
         data_out_q    <= data_out_d;
         valid_q       <= valid_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
      end
   end

   assign data_out       = data_out_q;
   assign data_out_valid = valid_q;
   assign frame_error    = frame_error_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver. Runs at TICK_DIV=16 (bit time 256 clks)
// so the whole sequence stays short; timing expectations are scaled to match.
module tb_uart_frame_receiver;
   import uart_pkg::*;

   localparam int CLK_F  = 100_000_000;
   localparam int BAUD   = 390_625;
   localparam int OS     = 16;
   localparam int BIT    = 256;
   localparam int LAT    = 9 * BIT + 9 * 16 + 3;   // start edge to valid, in clks

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       serial_in = 1'b1;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready = 1'b1;
   logic       frame_error;
   logic       overrun;

   int vectors = 0;
   int miscompares = 0;

   uart_frame_receiver #(
      .CLOCK_FREQ (CLK_F),
      .BAUD_RATE  (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .serial_in      (serial_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .frame_error    (frame_error),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: logs accepted bytes and counts flag pulses and valid cycles.
   logic [7:0] rx_log [0:63];
   int   rx_wr = 0;
   int   fe_cnt = 0;
   int   ov_cnt = 0;
   int   vhi_cnt = 0;
   int   rise_cyc = 0;
   logic valid_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (data_out_valid && data_out_ready) begin
            rx_log[rx_wr % 64] <= data_out;
            rx_wr <= rx_wr + 1;
         end
         if (frame_error) fe_cnt <= fe_cnt + 1;
         if (overrun) ov_cnt <= ov_cnt + 1;
         if (data_out_valid) vhi_cnt <= vhi_cnt + 1;
         if (data_out_valid && !valid_prev) rise_cyc <= cyc;
      end
      valid_prev <= data_out_valid;
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached (got no finish, required finish)");
      $fatal(1, "watchdog");
   end

   int tx_start = 0;

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 serial_in = fr[i];
         if (i == 0) tx_start = cyc;
         repeat (bclk - 1) @(posedge clk);
      end
      @(posedge clk);
      #1 serial_in = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h want=00", data_out); end
      vectors++; if (data_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", data_out_valid); end
      vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_fe got=%b want=0", frame_error); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ov got=%b want=0", overrun); end
      rst_n = 1'b1;
      idle(20);
      vectors++; if (data_out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got=%b want=0", data_out_valid); end
      $display("test_reset done");
   endtask

   task automatic test_single_byte();
      int base, fe0, ov0, vh0;
      data_out_ready = 1'b1;
      base = rx_wr; fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vhi_cnt;
      send_frame(8'h55, BIT, 1'b1);
      idle(100);
      vectors++;
      if (rx_wr - base !== 1) begin miscompares++; $display("FAIL single_count got=%0d want=1", rx_wr - base); end
      else begin
         vectors++; if (rx_log[base % 64] !== 8'h55) begin miscompares++; $display("FAIL single_data got=%h want=55", rx_log[base % 64]); end
      end
      vectors++;
      if (rise_cyc - tx_start < LAT - 8 || rise_cyc - tx_start > LAT + 8) begin
         miscompares++; $display("FAIL single_latency got=%0d want=%0d+/-8", rise_cyc - tx_start, LAT);
      end
      vectors++; if (vhi_cnt - vh0 !== 1) begin miscompares++; $display("FAIL single_valid_cycles got=%0d want=1", vhi_cnt - vh0); end
      vectors++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin miscompares++; $display("FAIL single_flags got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
      $display("test_single_byte 0x55 latency=%0d", rise_cyc - tx_start);
   endtask

   task automatic test_glitch();
      int base, fe0;
      base = rx_wr; fe0 = fe_cnt;
      @(posedge clk);
      #1 serial_in = 1'b0;
      idle(90);
      serial_in = 1'b1;
      idle(600);
      vectors++; if (rx_wr - base !== 0) begin miscompares++; $display("FAIL glitch_valid got=%0d bytes want=0", rx_wr - base); end
      vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL glitch_fe got=%0d want=0", fe_cnt - fe0); end
      vectors++; if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL glitch_state got=%0d want=%0d", dut.state_q, IDLE); end
      $display("test_glitch 90-clk low pulse");
   endtask

   task automatic test_framing();
      int base, fe0;
      base = rx_wr; fe0 = fe_cnt;
      send_frame(8'hA3, BIT, 1'b0);
      idle(600);
      vectors++; if (fe_cnt - fe0 !== 1) begin miscompares++; $display("FAIL framing_fe got=%0d want=1", fe_cnt - fe0); end
      vectors++; if (rx_wr - base !== 0) begin miscompares++; $display("FAIL framing_valid got=%0d bytes want=0", rx_wr - base); end
      send_frame(8'h3C, BIT, 1'b1);
      idle(100);
      vectors++;
      if (rx_wr - base !== 1) begin miscompares++; $display("FAIL framing_next_count got=%0d want=1", rx_wr - base); end
      else begin
         vectors++; if (rx_log[base % 64] !== 8'h3C) begin miscompares++; $display("FAIL framing_next_data got=%h want=3c", rx_log[base % 64]); end
      end
      vectors++; if (fe_cnt - fe0 !== 1) begin miscompares++; $display("FAIL framing_fe_after got=%0d want=1", fe_cnt - fe0); end
      $display("test_framing 0xA3 bad stop, then 0x3C");
   endtask

   task automatic test_back_to_back();
      int base, ov0;
      data_out_ready = 1'b0;
      base = rx_wr; ov0 = ov_cnt;
      send_frame(8'h11, BIT, 1'b1);
      send_frame(8'h22, BIT, 1'b1);
      idle(100);
      vectors++; if (data_out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got=%b want=1", data_out_valid); end
      vectors++; if (data_out !== 8'h11) begin miscompares++; $display("FAIL b2b_data got=%h want=11", data_out); end
      vectors++; if (ov_cnt - ov0 !== 1) begin miscompares++; $display("FAIL b2b_overrun got=%0d want=1", ov_cnt - ov0); end
      data_out_ready = 1'b1;
      idle(3);
      vectors++;
      if (rx_wr - base !== 1) begin miscompares++; $display("FAIL b2b_pop_count got=%0d want=1", rx_wr - base); end
      else begin
         vectors++; if (rx_log[base % 64] !== 8'h11) begin miscompares++; $display("FAIL b2b_pop_data got=%h want=11", rx_log[base % 64]); end
      end
      vectors++; if (data_out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_drop got=%b want=0", data_out_valid); end
      vectors++; if (data_out !== 8'h11) begin miscompares++; $display("FAIL b2b_data_hold got=%h want=11", data_out); end
      $display("test_back_to_back 0x11,0x22 ready=0");
   endtask

   task automatic test_baud_offset(input int bclk);
      int base, fe0, ov0;
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h80;
      data_out_ready = 1'b1;
      base = rx_wr; fe0 = fe_cnt; ov0 = ov_cnt;
      for (int k = 0; k < 3; k++) send_frame(exp_b[k], bclk, 1'b1);
      idle(300);
      vectors++;
      if (rx_wr - base !== 3) begin miscompares++; $display("FAIL baud%0d_count got=%0d want=3", bclk, rx_wr - base); end
      else begin
         for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rx_log[(base + k) % 64] !== exp_b[k]) begin
               miscompares++; $display("FAIL baud%0d_data%0d got=%h want=%h", bclk, k, rx_log[(base + k) % 64], exp_b[k]);
            end
         end
      end
      vectors++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin miscompares++; $display("FAIL baud%0d_flags got fe=%0d ov=%0d want 0 0", bclk, fe_cnt - fe0, ov_cnt - ov0); end
      $display("test_baud_offset bit=%0d clks 0x00,0xFF,0x80", bclk);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] partial;
      int base, fe0;
      partial = 8'h5A;
      vectors++; if (data_out !== 8'h80) begin miscompares++; $display("FAIL midrst_pre_data got=%h want=80", data_out); end
      @(posedge clk);
      #1 serial_in = 1'b0;
      idle(BIT - 1);
      for (int i = 0; i < 4; i++) begin
         serial_in = partial[i];
         idle(BIT);
      end
      serial_in = partial[4];
      idle(BIT / 2);
      rst_n = 1'b0;
      #1;
      vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL midrst_data got=%h want=00", data_out); end
      vectors++; if (data_out_valid !== 1'b0 || frame_error !== 1'b0 || overrun !== 1'b0) begin
         miscompares++; $display("FAIL midrst_flags got v=%b fe=%b ov=%b want 0 0 0", data_out_valid, frame_error, overrun);
      end
      serial_in = 1'b1;
      idle(10);
      rst_n = 1'b1;
      idle(50);
      base = rx_wr; fe0 = fe_cnt;
      send_frame(8'hC7, BIT, 1'b1);
      idle(100);
      vectors++;
      if (rx_wr - base !== 1) begin miscompares++; $display("FAIL midrst_next_count got=%0d want=1", rx_wr - base); end
      else begin
         vectors++; if (rx_log[base % 64] !== 8'hC7) begin miscompares++; $display("FAIL midrst_next_data got=%h want=c7", rx_log[base % 64]); end
      end
      vectors++; if (fe_cnt - fe0 !== 0) begin miscompares++; $display("FAIL midrst_next_fe got=%0d want=0", fe_cnt - fe0); end
      $display("test_reset_midframe then 0xC7");
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_baud_offset(261);
      test_baud_offset(251);
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
